// File: rtl/boot_loader_pkg.sv
// Shared types and helpers for the memory boot loader.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    BL_IDLE,
    BL_LOAD,
    BL_CHECK,
    BL_RUN,
    BL_DONE,
    BL_ERROR
  } bl_state_t;

  // Channel-select width; a single channel still needs one select bit.
  function automatic int bl_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic logic [127:0] BL_WE_ALL(input int be_w);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < be_w; i++) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/boot_ch_port.sv
// One memory channel: registered address/data with a single-cycle byte-enable strobe.
module boot_ch_port
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int BE_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [BE_W-1:0]   mem_we
);

  localparam logic [BE_W-1:0] WE_ALL = BE_W'(BL_WE_ALL(BE_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr <= '0;
      mem_data <= '0;
      mem_we   <= '0;
    end else begin
      mem_we <= wr ? WE_ALL : '0;
      if (wr) begin
        mem_addr <= wr_addr;
        mem_data <= wr_data;
      end
    end
  end

endmodule

// File: rtl/mem_boot_loader.sv
// Boot preload sequencer: host records become per-channel memory writes, then the core is released.
// Trailer checksum support is enabled by defining BOOT_LOADER_CKSUM_EN.
//   state | meaning
//   IDLE  | waiting for load_start
//   LOAD  | accepting records
//   CHECK | comparing accumulated sum against trailer
//   RUN   | core running, watching state_done / timeout
//   DONE  | core finished (sticky)
//   ERROR | bad channel, checksum mismatch or timeout (sticky)
module mem_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_CH      = 2,
  parameter int RUN_TIMEOUT = 0,
  localparam int CH_W = bl_ch_w(NUM_CH),
  localparam int BE_W = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic                     rec_valid,
  output logic                     rec_ready,
  input  logic [CH_W-1:0]          rec_ch,
  input  logic [ADDR_W-1:0]        rec_addr,
  input  logic [DATA_W-1:0]        rec_data,
  input  logic                     rec_last,
  output logic [NUM_CH*ADDR_W-1:0] mem_addr,
  output logic [NUM_CH*DATA_W-1:0] mem_data,
  output logic [NUM_CH*BE_W-1:0]   mem_we,
  output logic                     start_out,
  input  logic                     state_done,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [31:0]              rec_count
);

  localparam int TMR_W = (RUN_TIMEOUT > 0) ? $clog2(RUN_TIMEOUT + 1) : 1;

  bl_state_t        state, state_nxt;
  logic [TMR_W-1:0] tmr;
  logic             accept, load_go, ch_bad, is_trailer, wr_ok, tmo_hit;

  assign rec_ready = (state == BL_LOAD);
  assign accept    = rec_valid & rec_ready;
  assign load_go   = load_start & ((state == BL_IDLE) | (state == BL_DONE) | (state == BL_ERROR));
  assign ch_bad    = ({1'b0, rec_ch} >= (CH_W + 1)'(NUM_CH));
  assign tmo_hit   = (RUN_TIMEOUT != 0) && (tmr == TMR_W'(1));

`ifdef BOOT_LOADER_CKSUM_EN
  logic [DATA_W-1:0] acc, trailer;

  assign is_trailer = rec_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      trailer <= '0;
    end else if (load_go) begin
      acc <= '0;
    end else if (accept) begin
      if (rec_last) trailer <= rec_data;
      else          acc     <= acc + rec_data;
    end
  end
`else
  assign is_trailer = 1'b0;
`endif

  // The trailer beat carries the checksum only; its channel field is don't-care.
  assign wr_ok = accept & ~is_trailer & ~ch_bad;

  always_comb begin
    state_nxt = state;
    case (state)
      BL_IDLE, BL_DONE, BL_ERROR: if (load_start) state_nxt = BL_LOAD;
      BL_LOAD: begin
        if (accept) begin
          if (!is_trailer && ch_bad) state_nxt = BL_ERROR;
`ifdef BOOT_LOADER_CKSUM_EN
          else if (rec_last)         state_nxt = BL_CHECK;
`else
          else if (rec_last)         state_nxt = BL_RUN;
`endif
        end
      end
`ifdef BOOT_LOADER_CKSUM_EN
      BL_CHECK: state_nxt = (acc == trailer) ? BL_RUN : BL_ERROR;
`endif
      BL_RUN: begin
        if (state_done)   state_nxt = BL_DONE;
        else if (tmo_hit) state_nxt = BL_ERROR;
      end
      default: state_nxt = BL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= BL_IDLE;
    else       state <= state_nxt;
  end

  // Down-counter reloads whenever RUN is not active, so each RUN entry starts fresh.
  always_ff @(posedge clk) begin
    if (reset)                tmr <= TMR_W'(RUN_TIMEOUT);
    else if (state != BL_RUN) tmr <= TMR_W'(RUN_TIMEOUT);
    else if (tmr != '0)       tmr <= tmr - TMR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)        rec_count <= '0;
    else if (load_go) rec_count <= '0;
    else if (accept)  rec_count <= rec_count + 32'd1;
  end

  assign start_out = (state == BL_RUN);
  assign busy      = (state == BL_LOAD) | (state == BL_CHECK) | (state == BL_RUN);
  assign done      = (state == BL_DONE);
  assign error     = (state == BL_ERROR);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic wr;
    assign wr = wr_ok & (rec_ch == CH_W'(c));

    boot_ch_port #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_port (
      .clk      (clk),
      .reset    (reset),
      .wr       (wr),
      .wr_addr  (rec_addr),
      .wr_data  (rec_data),
      .mem_addr (mem_addr[c*ADDR_W +: ADDR_W]),
      .mem_data (mem_data[c*DATA_W +: DATA_W]),
      .mem_we   (mem_we[c*BE_W +: BE_W])
    );
  end

endmodule

// File: tb/tb_mem_boot_loader.sv
// Randomized self-checking bench for mem_boot_loader against a session-level reference model.
module tb_mem_boot_loader;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int NUM_CH      = 3;
  localparam int RUN_TIMEOUT = 16;
  localparam int CH_W        = 2;
  localparam int BE_W        = DATA_W / 8;

  logic                     clk = 1'b0;
  logic                     reset, load_start, rec_valid, rec_last, state_done;
  logic [CH_W-1:0]          rec_ch;
  logic [ADDR_W-1:0]        rec_addr;
  logic [DATA_W-1:0]        rec_data;
  logic                     rec_ready, start_out, busy, done, error;
  logic [NUM_CH*ADDR_W-1:0] mem_addr;
  logic [NUM_CH*DATA_W-1:0] mem_data;
  logic [NUM_CH*BE_W-1:0]   mem_we;
  logic [31:0]              rec_count;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q [NUM_CH][$];
  int  n_checks = 0;
  int  n_errors = 0;
  bit  cks;

  mem_boot_loader #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .NUM_CH      (NUM_CH),
    .RUN_TIMEOUT (RUN_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .rec_ch     (rec_ch),
    .rec_addr   (rec_addr),
    .rec_data   (rec_data),
    .rec_last   (rec_last),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .start_out  (start_out),
    .state_done (state_done),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .rec_count  (rec_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every observed strobe must match the oldest outstanding write for that channel.
  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (mem_we[c*BE_W +: BE_W] != '0) begin
        wr_t e;
        check("we_mask", mem_we[c*BE_W +: BE_W], {BE_W{1'b1}});
        check("wr_pending", exp_q[c].size() > 0, 1);
        if (exp_q[c].size() > 0) begin
          e = exp_q[c].pop_front();
          check("wr_addr", mem_addr[c*ADDR_W +: ADDR_W], e.addr);
          check("wr_data", mem_data[c*DATA_W +: DATA_W], e.data);
        end
      end
    end
  end

  task automatic drive_rec(input int i, input int n, input int bad_idx, input bit directed,
                           input bit corrupt, inout logic [DATA_W-1:0] sum);
    int ch;
    ch       = directed ? (i % 2) : $urandom_range(0, NUM_CH - 1);
    if (i == bad_idx) ch = 3;
    rec_addr = $urandom;
    rec_data = directed ? DATA_W'((i + 1) * 16) : $urandom;
    rec_last = (i == n - 1);
    if (cks && rec_last) begin
      rec_data = corrupt ? sum + 1 : sum;
      ch       = $urandom_range(0, 3);
    end else begin
      sum = sum + rec_data;
    end
    rec_ch    = CH_W'(ch);
    rec_valid = 1'b1;
    if (i != bad_idx && !(cks && rec_last)) exp_q[ch].push_back('{rec_addr, rec_data});
  endtask

  task automatic end_checks(input int exp_cnt);
    check("cnt_final", rec_count, exp_cnt);
    check("start_low", start_out, 0);
    check("busy_low", busy, 0);
    for (int c = 0; c < NUM_CH; c++) check("wr_left", exp_q[c].size(), 0);
  endtask

  task automatic run_session(input int n, input bit throttle, input int bad_idx, input int done_delay,
                             input bit corrupt, input bit early_done, input bit poke_ls,
                             input bit directed);
    logic [DATA_W-1:0] sum;
    int cyc, exp_run;
    sum        = '0;
    state_done = early_done;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    @(negedge clk);
    check("ready_rise", rec_ready, 1);
    check("busy_load", busy, 1);
    check("cnt_clr", rec_count, 0);
    for (int i = 0; i < n; i++) begin
      if (throttle) begin
        rec_valid = 1'b0;
        tick();
        tick();
      end
      drive_rec(i, n, bad_idx, directed, corrupt, sum);
      tick();
      if (i == bad_idx) begin
        rec_valid = 1'b0;
        rec_last  = 1'b0;
        @(negedge clk);
        check("bad_err", error, 1);
        check("bad_ready", rec_ready, 0);
        check("bad_we", mem_we, 0);
        end_checks(i + 1);
        state_done = 1'b0;
        return;
      end
    end
    rec_valid = 1'b0;
    rec_last  = 1'b0;
    @(negedge clk);
    check("ready_drop", rec_ready, 0);
    if (cks) begin
      check("chk_nostart", start_out, 0);
      check("chk_busy", busy, 1);
      @(negedge clk);
      if (corrupt) begin
        check("ck_err", error, 1);
        end_checks(n);
        state_done = 1'b0;
        return;
      end
    end
    check("start_rise", start_out, 1);
    cyc = 1;
    for (int k = 0; k < 40; k++) begin
      if (cyc == done_delay) state_done = 1'b1;
      load_start = poke_ls && (cyc == 2);
      @(negedge clk);
      if (!start_out) break;
      cyc++;
    end
    load_start = 1'b0;
    state_done = 1'b0;
    exp_run    = (done_delay <= RUN_TIMEOUT) ? done_delay : RUN_TIMEOUT;
    check("run_cycles", cyc, exp_run);
    check("run_done", done, done_delay <= RUN_TIMEOUT);
    check("run_err", error, done_delay > RUN_TIMEOUT);
    end_checks(n);
  endtask

  task automatic reset_mid_load();
    logic [DATA_W-1:0] sum;
    sum        = '0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_rec(i, 10, -1, 1'b0, 1'b0, sum);
      tick();
    end
    rec_addr = $urandom;
    rec_data = $urandom;
    rec_ch   = 2'd0;
    reset    = 1'b1;
    tick();
    @(negedge clk);
    check("rst_ready", rec_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_start", start_out, 0);
    check("rst_flags", {busy, done, error}, 0);
    check("rst_addr0", mem_addr[ADDR_W-1:0], 0);
    check("rst_data0", mem_data[DATA_W-1:0], 0);
    check("rst_cnt", rec_count, 0);
    reset     = 1'b0;
    rec_valid = 1'b0;
    tick();
    @(negedge clk);
    check("post_rst_idle", rec_ready, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef BOOT_LOADER_CKSUM_EN
    cks = 1'b1;
`else
    cks = 1'b0;
`endif
    reset      = 1'b1;
    load_start = 1'b0;
    rec_valid  = 1'b0;
    rec_last   = 1'b0;
    state_done = 1'b0;
    rec_ch     = '0;
    rec_addr   = '0;
    rec_data   = '0;
    tick();
    tick();
    @(negedge clk);
    check("reset_ready", rec_ready, 0);
    check("reset_we", mem_we, 0);
    check("reset_flags", {start_out, busy, done, error}, 0);
    check("reset_bus", {mem_addr, mem_data}, 0);
    check("reset_cnt", rec_count, 0);
    reset = 1'b0;
    tick();

    // n, throttle, bad_idx, done_delay, corrupt, early_done, poke_ls, directed
    run_session(4,   0, -1,   3, 0, 0, 0, 1);
    run_session(4,   0, -1,   2, 1, 0, 0, 1);
    run_session(5,   0, -1,   1, 0, 1, 1, 0);
    run_session(3,   0, -1, 100, 0, 0, 0, 0);
    run_session(4,   0,  2,   3, 0, 0, 0, 0);
    reset_mid_load();
    run_session(6,   0, -1,   4, 0, 0, 1, 0);
    run_session(100, 1, -1,  16, 0, 0, 0, 0);
    for (int s = 0; s < 6; s++)
      run_session($urandom_range(2, 12), 1'($urandom_range(0, 1)), -1, $urandom_range(1, 20),
                  1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
